// File: rtl/aes_ct_buffer.sv
// Ciphertext capture FIFO between the AES-192 core output and the register read path.
// Optional macro AES_CT_BUF_DEBUG_FLUSH_EN: debug_mode_i flushes the FIFO and blocks captures and reads.
module aes_ct_buffer #(
  parameter int DEPTH = 4,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [127:0]     ct_i,
  input  logic             ct_valid_i,
  input  logic             rd_req_i,
  input  logic             lock_i,
  input  logic             clr_i,
  input  logic             debug_mode_i,
  output logic [31:0]      rd_data_o,
  output logic             rd_valid_o,
  output logic             rd_err_o,
  output logic [LVL_W-1:0] level_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             overflow_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [127:0]     mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [1:0]       wsel;
  logic [LVL_W-1:0] level_q;
  logic             vld_q;
  logic             overflow_q;

  logic        flush;
  logic        cap;
  logic        rd_ok;
  logic        pop;
  logic        cap_ok;
  logic        cap_drop;
  logic [31:0] head_word;

`ifdef AES_CT_BUF_DEBUG_FLUSH_EN
  // Debug mode acts as a continuous flush so ciphertext cannot be pulled out.
  assign flush = clr_i | debug_mode_i;
`else
  logic unused_debug_mode;
  assign unused_debug_mode = debug_mode_i;
  assign flush = clr_i;
`endif

  assign empty_o    = (level_q == '0);
  assign full_o     = (level_q == FULL_LVL);
  assign level_o    = level_q;
  assign overflow_o = overflow_q;

  assign cap    = ct_valid_i & ~vld_q;
  assign rd_ok  = rd_req_i & ~empty_o & ~lock_i & ~flush;
  assign pop    = rd_ok & (wsel == 2'd3);
  // A final-word pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign cap_ok   = cap & ~flush & (~full_o | pop);
  assign cap_drop = cap & ~flush & full_o & ~pop;

  assign head_word = mem[rd_ptr][32*wsel +: 32];

  always_ff @(posedge clk_i) begin
    if (cap_ok) begin
      mem[wr_ptr] <= ct_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q      <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      wsel       <= 2'd0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      rd_data_o  <= 32'd0;
      rd_valid_o <= 1'b0;
      rd_err_o   <= 1'b0;
    end else begin
      vld_q      <= ct_valid_i;
      rd_valid_o <= rd_ok;
      rd_err_o   <= rd_req_i & ~rd_ok;
      rd_data_o  <= rd_ok ? head_word : 32'd0;
      if (flush) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        wsel       <= 2'd0;
        level_q    <= '0;
        overflow_q <= 1'b0;
      end else begin
        if (cap_ok) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (rd_ok) begin
          wsel <= wsel + 2'd1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        level_q <= level_q + LVL_W'(cap_ok) - LVL_W'(pop);
        if (cap_drop) begin
          overflow_q <= 1'b1;
        end
      end
    end
  end

endmodule
